// File: rtl/counter_ctrl.sv
// counter_ctrl: sequences the downstream counter through load and run phases.
// It provides a programmable prescaler, one-shot and periodic (auto-reload)
// modes, a one-cycle done pulse and a saturating count of wrap events.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | counter frozen, waiting for start
// LOAD  | one cycle: load latched reload value into counter
// RUN   | prescaler running, counter enabled once per PRESCALE+1 clocks
module counter_ctrl #(
  parameter int WIDTH       = 8,
  parameter int PRESC_WIDTH = 8,
  parameter int WRAP_WIDTH  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   mode,
  input  logic [PRESC_WIDTH-1:0] prescale,
  input  logic [WIDTH-1:0]       reload_value,
  input  logic                   irq_in,
  output logic                   enable,
  output logic                   load,
  output logic [WIDTH-1:0]       load_value,
  output logic                   busy,
  output logic                   done,
  output logic [WRAP_WIDTH-1:0]  wrap_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t                 state;
  logic                   mode_q;
  logic [PRESC_WIDTH-1:0] prescale_q;
  logic [WIDTH-1:0]       reload_q;
  logic [PRESC_WIDTH-1:0] presc_cnt;
  logic                   presc_hit;

  // Prescaler terminal count; only meaningful while running.
  assign presc_hit = (presc_cnt == prescale_q);

  // Outputs decode registered state only, so reset clears them at once and
  // no input ever reaches an output combinationally.
  assign enable     = (state == RUN) && presc_hit;
  assign load       = (state == LOAD);
  assign busy       = (state != IDLE);
  assign load_value = reload_q;

  // Sequencer: stop beats start, start beats a coincident wrap event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      mode_q     <= 1'b0;
      prescale_q <= '0;
      reload_q   <= '0;
      presc_cnt  <= '0;
      done       <= 1'b0;
      wrap_count <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !stop) begin
            mode_q     <= mode;
            prescale_q <= prescale;
            reload_q   <= reload_value;
            wrap_count <= '0;
            state      <= LOAD;
          end
        end

        LOAD: begin
          presc_cnt <= '0;
          if (stop) begin
            state <= IDLE;
          end else if (start) begin
            mode_q     <= mode;
            prescale_q <= prescale;
            reload_q   <= reload_value;
            wrap_count <= '0;
            state      <= LOAD;
          end else begin
            state <= RUN;
          end
        end

        RUN: begin
          if (presc_hit) begin
            presc_cnt <= '0;
          end else begin
            presc_cnt <= presc_cnt + PRESC_WIDTH'(1);
          end

          if (stop) begin
            state <= IDLE;
          end else if (start) begin
            mode_q     <= mode;
            prescale_q <= prescale;
            reload_q   <= reload_value;
            wrap_count <= '0;
            state      <= LOAD;
          end else if (irq_in) begin
            if (wrap_count != '1) begin
              wrap_count <= wrap_count + WRAP_WIDTH'(1);
            end
            if (mode_q) begin
              state <= IDLE;
              done  <= 1'b1;
            end else begin
              state <= LOAD;
            end
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
